// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_valid, i_op, i_a, i_b, i_flush, i_ready,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: one bit per cycle through a shared {hi,lo} shift datapath,
// operands reduced to magnitudes at accept and the result sign restored in FIX.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi, lo;
    logic [XLEN-1:0] result_q;
    logic            valid_q;
    logic            accept;

    // Operand conditioning at accept
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            res_neg;

    always_comb begin
        a_signed = (bus.i_op == 3'd1) || (bus.i_op == 3'd2) ||
                   (bus.i_op == 3'd4) || (bus.i_op == 3'd6);
        b_signed = (bus.i_op == 3'd1) || (bus.i_op == 3'd4) || (bus.i_op == 3'd6);
        neg_a    = a_signed && bus.i_a[XLEN-1];
        neg_b    = b_signed && bus.i_b[XLEN-1];
        a_mag    = neg_a ? (~bus.i_a + 1'b1) : bus.i_a;
        b_mag    = neg_b ? (~bus.i_b + 1'b1) : bus.i_b;
        div_zero = bus.i_op[2] && (bus.i_b == '0);
        div_ovf  = bus.i_op[2] && !bus.i_op[0] &&
                   (bus.i_a == MIN_NEG) && (bus.i_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = bus.i_op[1] ? bus.i_a : '1;
        else
            special_res = bus.i_op[1] ? '0 : MIN_NEG;
        // Remainder follows the dividend; everything else is sign(a)^sign(b)
        res_neg  = (bus.i_op[2] && bus.i_op[1]) ? neg_a : (neg_a ^ neg_b);
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   hi_n, lo_n;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_shift[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
        case (op_q)
            3'd0:          fix_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_res = neg_q ? (~lo + 1'b1) : lo;
            default:       fix_res = neg_q ? (~hi + 1'b1) : hi;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        bus.o_ready = (state == S_IDLE);
        case (state)
            S_IDLE: begin
                if (bus.i_valid && !bus.i_flush) begin
                    accept  = 1'b1;
                    state_n = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.i_flush)                     state_n = S_IDLE;
                else if (cnt == CW'(XLEN-1))         state_n = S_FIX;
            end
            S_FIX: begin
                state_n = bus.i_flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (bus.i_flush || bus.i_ready)      state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state_n == S_DONE);
            if (accept) begin
                op_q  <= bus.i_op;
                neg_q <= res_neg;
                b_q   <= b_mag;
                hi    <= '0;
                lo    <= a_mag;
                cnt   <= '0;
                if (special) result_q <= special_res;
            end else if (state == S_BUSY && !bus.i_flush) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + 1'b1;
            end else if (state == S_FIX && !bus.i_flush) begin
                result_q <= fix_res;
            end
        end
    end

    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] sb_q[$];

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib, q;
        logic [31:0] r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a}; ub = {32'b0, b};
        ia = $signed(a); ib = $signed(b);
        p = 0; q = 0; r = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin q = ia / ib; r = q; end
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else begin q = ia % ib; r = q; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one request, wait for its result, optionally stall, then retire it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int lat, exp_lat;
        logic [31:0] held, exp_v;
        exp_lat = (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 0 : 33;
        check({tag, "_ready_pre"}, {31'b0, bus.o_ready}, 32'd1);
        bus.i_op = op; bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back(exp);
        bus.i_valid = 1'b0;
        bus.i_a = $urandom; bus.i_b = $urandom; bus.i_op = 3'($urandom);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ready_busy"}, {31'b0, bus.o_ready}, 32'd0);
        held = bus.o_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'b0, bus.o_valid}, 32'd1);
            check({tag, "_hold_result"}, bus.o_result, held);
            check({tag, "_hold_ready"}, {31'b0, bus.o_ready}, 32'd0);
        end
        exp_v = sb_q.pop_front();
        check({tag, "_result"}, bus.o_result, exp_v);
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        check({tag, "_retired"}, {30'b0, bus.o_valid, bus.o_ready}, 32'b01);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int seen;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
        bus.i_flush = 1'b0; bus.i_ready = 1'b0;
        #12;
        check("reset_ready", {31'b0, bus.o_ready}, 32'd1);
        check("reset_valid", {31'b0, bus.o_valid}, 32'd0);
        check("reset_result", bus.o_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul",    3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("mulh",   3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("div",    3'd4, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 0);
        run_op("rem",    3'd6, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 0);
        run_op("divu",   3'd5, 32'd20,         32'd6,        32'd3,        0);
        run_op("remu",   3'd7, 32'd20,         32'd6,        32'd2,        0);
        run_op("div0",   3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 0);
        run_op("remu0",  3'd7, 32'd5,          32'd0,        32'd5,        0);
        run_op("divovf", 3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0);
        run_op("removf", 3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 0);
        run_op("bp",     3'd1, 32'h12345678,   32'hF0000001, ref_res(3'd1, 32'h12345678, 32'hF0000001), 10);

        for (int i = 0; i < 8; i++) begin
            rop = 3'(i);
            ra = $urandom; rb = $urandom;
            if (i == 5) rb = rb >> 20;
            run_op("rand", rop, ra, rb, ref_res(rop, ra, rb), 0);
        end

        // Flush in IDLE blocks acceptance
        bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 3'd0; bus.i_a = 32'd3; bus.i_b = 32'd3;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        check("idle_flush_ready", {31'b0, bus.o_ready}, 32'd1);

        // Flush at iteration 15
        bus.i_valid = 1'b1; bus.i_op = 3'd0; bus.i_a = 32'd9; bus.i_b = 32'd9;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("flush_busy", {31'b0, bus.o_ready}, 32'd0);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_idle", {31'b0, bus.o_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.o_valid === 1'b1) seen++;
        end
        check("flush_no_valid", seen, 32'd0);

        // Asynchronous reset mid-operation
        bus.i_valid = 1'b1; bus.i_op = 3'd3; bus.i_a = 32'hDEADBEEF; bus.i_b = 32'h1234;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, bus.o_valid}, 32'd0);
        check("arst_ready", {31'b0, bus.o_ready}, 32'd1);
        check("arst_result", bus.o_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
